// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Optional early termination is selected by defining MUL_EARLY_TERM_EN.
package mul_pkg;

  // Default operand widths
  localparam int A_W_DEF = 8;
  localparam int B_W_DEF = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the full product: wide enough for (2^a_w-1)*(2^b_w-1)
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier and the
// product holding register. Sequenced by load/step/fin from mul_shift_add.
// With MUL_EARLY_TERM_EN defined it also reports the last useful step and
// can force a zero product for a zero multiplier.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          step,
  input  logic                          fin,
`ifdef MUL_EARLY_TERM_EN
  input  logic                          fin_zero,
  output logic                          run_last,
`endif
  input  logic [A_W-1:0]                a,
  input  logic [B_W-1:0]                b,
  output logic [prod_w(A_W, B_W)-1:0]   product
);

  localparam int P_W = prod_w(A_W, B_W);

  logic [P_W-1:0] acc_r;
  logic [P_W-1:0] mcand_r;
  logic [B_W-1:0] mplier_r;
  logic [P_W-1:0] product_r;
  logic [P_W-1:0] acc_sum_s;

  // Accumulator plus the multiplicand when the current multiplier bit is set
  always_comb begin
    acc_sum_s = acc_r;
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

`ifdef MUL_EARLY_TERM_EN
  // Last step when no set bits remain above the current one
  assign run_last = ((mplier_r >> 1) == {B_W{1'b0}});
`endif

  // Operand load and one shift-add step per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{B_W{1'b0}}, a};
      mplier_r <= b;
    end else if (step) begin
      acc_r    <= acc_sum_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  // Product register: updated only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= '0;
    end else if (fin) begin
`ifdef MUL_EARLY_TERM_EN
      product_r <= fin_zero ? {P_W{1'b0}} : acc_sum_s;
`else
      product_r <= acc_sum_s;
`endif
    end else begin
      product_r <= product_r;
    end
  end

  assign product = product_r;

endmodule

// File: rtl/mul_shift_add.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock,
// start/busy/done handshake, product held until the next completion.
// Define MUL_EARLY_TERM_EN to stop as soon as no multiplier bits remain.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [A_W-1:0]                a,
  input  logic [B_W-1:0]                b,
  output logic                          busy,
  output logic                          done,
  output logic [prod_w(A_W, B_W)-1:0]   product
);

  localparam int CNT_W = $clog2(B_W + 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;
  logic             load_s;
  logic             step_s;
  logic             fin_s;
  logic             busy_s;
  logic             done_s;
  logic             busy_r;
  logic             done_r;

`ifdef MUL_EARLY_TERM_EN
  logic zero_b_s;
  logic run_last_s;
  assign zero_b_s = (b == {B_W{1'b0}});
  assign last_s   = run_last_s;
`else
  assign last_s   = (cnt_r == CNT_W'(B_W - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; IDLE and DONE both accept a new start
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
`ifdef MUL_EARLY_TERM_EN
          state_next_s = zero_b_s ? ST_DONE : ST_RUN;
`else
          state_next_s = ST_RUN;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath controls and next-cycle handshake levels
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    fin_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        load_s = start;
      end
      ST_RUN: begin
        step_s = 1'b1;
        fin_s  = last_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
`ifdef MUL_EARLY_TERM_EN
    fin_s  = fin_s | (load_s & zero_b_s);
`endif
    busy_s = (state_next_s == ST_RUN);
    done_s = (state_next_s == ST_DONE);
  end

  // Registered handshake outputs, aligned with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Step counter: bounds RUN to B_W iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= '0;
    end else if (step_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  mul_datapath #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .step     (step_s),
    .fin      (fin_s),
`ifdef MUL_EARLY_TERM_EN
    .fin_zero (zero_b_s),
    .run_last (run_last_s),
`endif
    .a        (a),
    .b        (b),
    .product  (product)
  );

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mul_shift_add.sv
// Scoreboard bench for mul_shift_add: stimulus pushes expected product and
// completion cycle, a negedge monitor pops and compares on every done.
module tb_mul_shift_add;

  localparam int A_W = 8;
  localparam int B_W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [A_W-1:0] a_i = '0;
  logic [B_W-1:0] b_i = '0;
  logic           busy;
  logic           done;
  logic [A_W+B_W-1:0] product;

  typedef struct {
    int unsigned prod;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_prod = 0;

  mul_shift_add #(.A_W(A_W), .B_W(B_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of clock edges from accepting start to entering DONE
  function automatic int unsigned exp_edges(input int unsigned bv);
`ifdef MUL_EARLY_TERM_EN
    int unsigned hi;
    if (bv == 0) return 0;
    hi = 0;
    for (int i = 0; i < B_W; i++) if ((bv >> i) & 1) hi = i;
    return hi + 1;
`else
    return B_W;
`endif
  endfunction

  // Monitor: pops one expectation per done pulse, otherwise checks hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", product, e.prod);
          chk("done_cycle", cyc, e.cyc);
          last_prod = e.prod;
        end
      end else begin
        chk("product_hold", product, last_prod);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // One isolated operation, also counting busy cycles
  task automatic run_op(input int unsigned av, input int unsigned bv);
    int unsigned lat;
    int unsigned nb;
    exp_t e;
    @(negedge clk);
    start = 1'b1; a_i = av[A_W-1:0]; b_i = bv[B_W-1:0];
    @(posedge clk); #1;
    lat = exp_edges(bv);
    e.prod = av * bv; e.cyc = cyc + lat;
    q.push_back(e);
    nb = 0;
    for (int k = 0; k <= int'(lat); k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) nb++;
    end
    chk("busy_cycles", nb, lat);
    wait_idle();
  endtask

  initial begin
    int unsigned lat1;
    int unsigned lat2;
    exp_t e;
    int directed_a[10] = '{137, 221, 127, 255,  0,  8, 34, 44, 200, 77};
    int directed_b[10] = '{  4,   5,   9,  15, 15, 10,  4,  5,   0,  1};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(directed_a[i], directed_b[i]);

    // Back-to-back with start held high through DONE
    @(negedge clk);
    start = 1'b1; a_i = 8'd221; b_i = 4'd5;
    @(posedge clk); #1;
    lat1 = exp_edges(5);
    e.prod = 1105; e.cyc = cyc + lat1; q.push_back(e);
    for (int k = 0; k < int'(lat1); k++) @(posedge clk);
    @(negedge clk);
    a_i = 8'd127; b_i = 4'd9;
    @(posedge clk); #1;
    lat2 = exp_edges(9);
    e.prod = 1143; e.cyc = cyc + lat2; q.push_back(e);
    @(negedge clk); start = 1'b0;
    wait_idle();
    @(negedge clk);

    // start pulses and operand changes during RUN are ignored
    @(negedge clk);
    start = 1'b1; a_i = 8'd100; b_i = 4'd13;
    @(posedge clk); #1;
    lat1 = exp_edges(13);
    e.prod = 1300; e.cyc = cyc + lat1; q.push_back(e);
    for (int k = 0; k < int'(lat1); k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a_i = 8'($urandom); b_i = 4'($urandom);
    end
    @(negedge clk); start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a_i = 8'd255; b_i = 4'd15;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_product", product, 0);
    q.delete();
    last_prod = 0;
    @(negedge clk); rst_n = 1'b1;
    run_op(137, 4);

    // Randomized operations
    for (int i = 0; i < 30; i++) run_op($urandom_range(0, 255), $urandom_range(0, 15));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
